dm_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port data RAM (8-bit byte address, 32-bit data, size/sign-extend controls, synchronous read).
- Shares the RAM between the CPU load/store path and a read-only debug/display port; the debug port lets the board show memory words on the 7-segment display.
- CPU has fixed priority, with a starvation guard for the debug port.
- The CPU control unit stalls on `cpu_gnt`/`cpu_rvalid` instead of assuming a fixed memory latency.

---
 rtl/dm_arbiter_if.sv | 61 ++++++
 rtl/dm_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if - bus bundle between the data-RAM arbiter, its two requesters
// (CPU load/store path, debug/display read port) and the single-port RAM.
//
// Signal groups:
//   cpu_*  : CPU request (req/we/addr/wdata/size/se) and response (gnt/rvalid/rdata)
//   dbg_*  : debug read request (req/addr) and response (gnt/rvalid/rdata)
//   ram_*  : RAM address/control/write data out, ram_rdata back (one cycle after address)
//   cpu_stall_cnt : CPU stall cycle counter (zero unless built with DM_ARB_STALL_CNT_EN)
//
// Modports:
//   slave  : the arbiter
//   master : the requesters plus the RAM (the environment around the arbiter)
interface dm_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [1:0]    cpu_size;
  logic          cpu_se;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [1:0]    ram_size;
  logic          ram_se;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [15:0]   cpu_stall_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_se,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_addr, ram_we, ram_size, ram_se, ram_wdata,
    input  ram_rdata,
    output cpu_stall_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_se,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_addr, ram_we, ram_size, ram_se, ram_wdata,
    output ram_rdata,
    input  cpu_stall_cnt
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter - two-requester arbiter/sequencer for the single-port data RAM.
//
// The CPU load/store path has fixed priority over the read-only debug port;
// after STARVE_LIMIT consecutive CPU wins over a waiting debug request the
// debug port is forced through (STARVE_LIMIT = 0 gives pure CPU priority).
// Each access is IDLE/WAIT -> ISSUE (gnt, RAM driven) -> WAIT (RAM read data
// arrives) -> rvalid on the following cycle. A new arbitration happens at the
// WAIT exit edge, so back-to-back accesses run at one per two cycles.
//
// Ports:
//   clk   : clock, rising edge
//   rst_  : asynchronous reset, active low
//   bus   : dm_arbiter_if.slave (CPU, debug and RAM signals)
//
// Build option:
//   DM_ARB_STALL_CNT_EN : when defined, bus.cpu_stall_cnt counts cycles with
//   cpu_req high and no cpu_gnt (16-bit, saturating, cleared only by reset);
//   otherwise it is tied to zero.
module dm_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst_,
  dm_arbiter_if.slave bus
);

  localparam int              SW       = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIM      = SW'(STARVE_LIMIT);
  localparam bit              GUARD_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner_dbg;   // owner of the access in flight
  logic          r_own_we;      // access in flight is a store
  logic [SW-1:0] r_starve;

  logic          r_cpu_gnt, r_cpu_rvalid;
  logic          r_dbg_gnt, r_dbg_rvalid;
  logic [DW-1:0] r_cpu_rdata, r_dbg_rdata;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [1:0]    r_ram_size;
  logic          r_ram_se;
  logic [DW-1:0] r_ram_wdata;

  logic          w_any;
  logic          w_arb;
  logic          w_dbg_win;
  logic [SW-1:0] w_starve_nxt;

  assign w_any     = bus.cpu_req | bus.dbg_req;
  // Arbitration edges: any edge in IDLE, and the WAIT exit edge.
  assign w_arb     = w_any && (r_state == S_IDLE || r_state == S_WAIT);
  assign w_dbg_win = bus.dbg_req && (!bus.cpu_req || (GUARD_EN && (r_starve == LIM)));

  // Starvation count only grows while debug is actually being passed over.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_dbg_win || !bus.dbg_req)
      w_starve_nxt = '0;
    else if (r_starve < LIM)
      w_starve_nxt = r_starve + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= S_IDLE;
      r_owner_dbg  <= 1'b0;
      r_own_we     <= 1'b0;
      r_starve     <= '0;
      r_cpu_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_size   <= '0;
      r_ram_se     <= 1'b0;
      r_ram_wdata  <= '0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_dbg_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;

      case (r_state)
        S_ISSUE: begin
          r_ram_we <= 1'b0;   // addr held through WAIT for the synchronous read
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // RAM read data for the ISSUE address is valid now.
          if (r_owner_dbg) begin
            r_dbg_rvalid <= 1'b1;
            r_dbg_rdata  <= bus.ram_rdata;
          end else begin
            r_cpu_rvalid <= 1'b1;
            if (!r_own_we)
              r_cpu_rdata <= bus.ram_rdata;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A winner found this edge overrides the fall-back to IDLE above.
      if (w_arb) begin
        r_state     <= S_ISSUE;
        r_starve    <= w_starve_nxt;
        r_owner_dbg <= w_dbg_win;
        if (w_dbg_win) begin
          r_dbg_gnt   <= 1'b1;
          r_own_we    <= 1'b0;
          r_ram_addr  <= bus.dbg_addr;
          r_ram_we    <= 1'b0;
          r_ram_size  <= 2'd2;
          r_ram_se    <= 1'b0;
          r_ram_wdata <= '0;
        end else begin
          r_cpu_gnt   <= 1'b1;
          r_own_we    <= bus.cpu_we;
          r_ram_addr  <= bus.cpu_addr;
          r_ram_we    <= bus.cpu_we;
          r_ram_size  <= bus.cpu_size;
          r_ram_se    <= bus.cpu_se;
          r_ram_wdata <= bus.cpu_wdata;
        end
      end
    end
  end

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dbg_gnt    = r_dbg_gnt;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_size   = r_ram_size;
  assign bus.ram_se     = r_ram_se;
  assign bus.ram_wdata  = r_ram_wdata;

`ifdef DM_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // A cycle is a stall when the CPU is asking and this cycle is not its grant.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      r_stall_cnt <= '0;
    else if (bus.cpu_req && !r_cpu_gnt && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign bus.cpu_stall_cnt = r_stall_cnt;
`else
  assign bus.cpu_stall_cnt = '0;
`endif

endmodule
